// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD digit type, limits and validity helper for the
//               packed-BCD up/down counter and its per-digit step cell.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int          DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // A digit is legal BCD only in the range 0..9; codes A..F are rejected.
    function automatic logic bcd_digit_valid(input bcd_digit_t d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : One combinational BCD digit stage of a ripple carry/borrow
//               chain. With step_in high the digit moves one place in the
//               direction given by up; step_out requests a step of the next
//               digit when this one rolls over (9->0 up, 0->9 down).
// Ports       : d        - current digit value
//               step_in  - carry (up) or borrow (down) request from below
//               up       - 1 = increment, 0 = decrement
//               d_next   - digit value after the step
//               step_out - carry/borrow request to the next digit
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t d_next,
    output logic       step_out
);

    always_comb begin
        d_next   = d;
        step_out = 1'b0;
        if (step_in) begin
            if (up) begin
                // >= rather than == so a stray illegal code still rolls to 0
                if (d >= DIGIT_MAX) begin
                    d_next   = '0;
                    step_out = 1'b1;
                end else begin
                    d_next = d + 4'd1;
                end
            end else begin
                if (d == '0) begin
                    d_next   = DIGIT_MAX;
                    step_out = 1'b1;
                end else begin
                    d_next = d - 4'd1;
                end
            end
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_counter
// Description : Parametrised multi-digit packed-BCD up/down counter with
//               synchronous load (rejecting non-BCD values), enable and a
//               registered single-cycle wrap/borrow pulse.
//               Optional build macro BCD_COUNTER_SAT_EN: saturate at
//               all-9s / zero instead of wrapping; wrap then flags every
//               enabled step blocked at a limit.
// Ports       : clk      - rising-edge clock
//               reset_n  - asynchronous active-low reset
//               en       - count enable (one step per cycle)
//               up       - direction, 1 = increment, 0 = decrement
//               load     - synchronous load request (highest priority)
//               load_val - packed BCD load value, digit 0 in [3:0]
//               count    - current packed BCD value
//               wrap     - one-cycle pulse after a roll-over (or blocked step)
//               load_err - one-cycle pulse after a rejected load
//               zero     - combinational, high when count is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    output logic [DIGIT_W*DIGITS-1:0] count,
    output logic                      wrap,
    output logic                      load_err,
    output logic                      zero
);

    localparam int c_W = DIGIT_W * DIGITS;

    logic [c_W-1:0]  r_count_q;
    logic            r_wrap_q;
    logic            r_load_err_q;

    logic [c_W-1:0]  w_count_d;
    logic            w_wrap_d;
    logic            w_load_err_d;

    logic [c_W-1:0]  w_stepped;
    logic [DIGITS:0] w_step;
    logic            w_limit;
    logic            w_load_ok;

    // Digit 0 always receives a step request; the result is used only when en.
    assign w_step[0] = 1'b1;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_step u_step (
                .d        (r_count_q[i*DIGIT_W +: DIGIT_W]),
                .step_in  (w_step[i]),
                .up       (up),
                .d_next   (w_stepped[i*DIGIT_W +: DIGIT_W]),
                .step_out (w_step[i+1])
            );
        end
    endgenerate

    // Carry/borrow out of the top digit: the count is at the limit for this direction.
    assign w_limit = w_step[DIGITS];

    always_comb begin
        w_load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_digit_valid(load_val[i*DIGIT_W +: DIGIT_W])) begin
                w_load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        w_count_d    = r_count_q;
        w_wrap_d     = 1'b0;
        w_load_err_d = 1'b0;
        if (load) begin
            // A rejected load also swallows any count step in this cycle.
            if (w_load_ok) begin
                w_count_d = load_val;
            end else begin
                w_load_err_d = 1'b1;
            end
        end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
            if (!w_limit) begin
                w_count_d = w_stepped;
            end
            w_wrap_d = w_limit;
`else
            w_count_d = w_stepped;
            w_wrap_d  = w_limit;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count_q    <= '0;
            r_wrap_q     <= 1'b0;
            r_load_err_q <= 1'b0;
        end else begin
            r_count_q    <= w_count_d;
            r_wrap_q     <= w_wrap_d;
            r_load_err_q <= w_load_err_d;
        end
    end

    assign count    = r_count_q;
    assign wrap     = r_wrap_q;
    assign load_err = r_load_err_q;
    assign zero     = (r_count_q == '0);

endmodule : bcd_counter
`default_nettype wire
